// File: rtl/twos_comp_deserializer.sv
// Serial two's-complement receiver: undoes the complement LSB-first,
// assembles a WIDTH-bit word and hands it out over valid/ready.
module twos_comp_deserializer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             t_clock,
   input  logic             r,
   input  logic             x,
   input  logic             x_valid,
   input  logic             x_start,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun
);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic             seen_one;
   logic [WIDTH-1:0] shreg;

   logic             d;
   logic             take;
   logic             last;
   logic [WIDTH-1:0] word_new;

   // Bits up to and including the first 1 pass through; later bits invert.
   assign d        = seen_one ? ~x : x;
   assign take     = (state == SHIFT) && x_valid && !x_start;
   assign last     = take && (count == CNT_W'(WIDTH - 1));
   assign word_new = {d, shreg[WIDTH-1:1]};

   always_ff @(posedge t_clock or negedge r) begin
      if (!r) begin
         state      <= IDLE;
         count      <= '0;
         seen_one   <= 1'b0;
         shreg      <= '0;
         word_out   <= '0;
         word_valid <= 1'b0;
         busy       <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         unique case (state)
            IDLE: begin
               if (x_valid && x_start) begin
                  shreg    <= {x, {(WIDTH-1){1'b0}}};
                  seen_one <= x;
                  count    <= CNT_W'(1);
                  state    <= SHIFT;
                  busy     <= 1'b1;
               end
            end
            SHIFT: begin
               if (x_valid && x_start) begin
                  frame_err <= 1'b1;
                  shreg     <= {x, {(WIDTH-1){1'b0}}};
                  seen_one  <= x;
                  count     <= CNT_W'(1);
               end else if (x_valid) begin
                  shreg    <= word_new;
                  seen_one <= seen_one | x;
                  count    <= count + CNT_W'(1);
                  if (last) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     count <= '0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase

         // A full, unread output slot wins over a newly completed frame.
         if (last) begin
            if (word_valid && !word_ready) begin
               overrun <= 1'b1;
            end else begin
               word_out   <= word_new;
               word_valid <= 1'b1;
            end
         end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_twos_comp_deserializer.sv
// Randomised bench for twos_comp_deserializer against an arithmetic
// frame-level reference (word = -frame mod 2**WIDTH).
module tb_twos_comp_deserializer;

   localparam int W = 4;

   logic         t_clock;
   logic         r;
   logic         x;
   logic         x_valid;
   logic         x_start;
   logic [W-1:0] word_out;
   logic         word_valid;
   logic         word_ready;
   logic         busy;
   logic         frame_err;
   logic         overrun;

   int total = 0;
   int bad   = 0;

   // reference state
   bit m_in;
   int m_n;
   int m_raw;
   bit m_wv;
   int m_wo;
   bit m_ov;
   bit m_fe;

   twos_comp_deserializer #(.WIDTH(W), .CNT_W(3)) dut (
      .t_clock    (t_clock),
      .r          (r),
      .x          (x),
      .x_valid    (x_valid),
      .x_start    (x_start),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .busy       (busy),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   initial t_clock = 1'b0;
   always #5 t_clock = ~t_clock;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_in  = 0;
      m_n   = 0;
      m_raw = 0;
      m_wv  = 0;
      m_wo  = 0;
      m_ov  = 0;
      m_fe  = 0;
   endtask

   task automatic m_step(input bit b, input bit v, input bit s, input bit rdy);
      bit done;
      done = 0;
      m_ov = 0;
      m_fe = 0;
      if (v) begin
         if (s) begin
            if (m_in) m_fe = 1;
            m_in  = 1;
            m_raw = b;
            m_n   = 1;
         end else if (m_in) begin
            m_raw = m_raw + (int'(b) << m_n);
            m_n++;
            if (m_n == W) begin
               done = 1;
               m_in = 0;
            end
         end
      end
      if (done) begin
         if (m_wv && !rdy) m_ov = 1;
         else begin
            m_wo = ((1 << W) - m_raw) % (1 << W);
            m_wv = 1;
         end
      end else if (m_wv && rdy) begin
         m_wv = 0;
      end
   endtask

   task automatic compare(input string tag);
      check({tag, ".valid"}, int'(word_valid), int'(m_wv));
      check({tag, ".word"}, int'(word_out), m_wo);
      check({tag, ".busy"}, int'(busy), int'(m_in));
      check({tag, ".ferr"}, int'(frame_err), int'(m_fe));
      check({tag, ".ovr"}, int'(overrun), int'(m_ov));
   endtask

   task automatic step(input bit b, input bit v, input bit s, input bit rdy,
                       input string tag);
      x          = b;
      x_valid    = v;
      x_start    = s;
      word_ready = rdy;
      @(posedge t_clock);
      m_step(b, v, s, rdy);
      #1;
      compare(tag);
   endtask

   task automatic idle(input int n, input bit rdy, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, tag);
   endtask

   task automatic send(input int raw, input int maxgap, input bit rdy,
                       input string tag);
      for (int i = 0; i < W; i++) begin
         int g;
         g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
         for (int k = 0; k < g; k++)
            step(1'($urandom), 1'b0, 1'($urandom), rdy, tag);
         step(1'((raw >> i) & 1), 1'b1, i == 0, rdy, tag);
      end
   endtask

   initial begin
      r          = 1'b0;
      x          = 1'b0;
      x_valid    = 1'b0;
      x_start    = 1'b0;
      word_ready = 1'b0;
      m_reset();
      repeat (2) @(posedge t_clock);
      #1;
      compare("reset");
      #2 r = 1'b1;

      // 0,1,0,1 -> 0110
      send(4'b1010, 0, 1'b1, "t1");
      check("t1.w", int'(word_out), 6);
      check("t1.v", int'(word_valid), 1);
      idle(1, 1'b1, "t1.drain");
      check("t1.low", int'(word_valid), 0);

      send(4'b0000, 0, 1'b1, "t2a");
      check("t2.zero", int'(word_out), 0);
      send(4'b1000, 0, 1'b1, "t2b");
      check("t2.minneg", int'(word_out), 8);
      idle(1, 1'b1, "t2.drain");

      // overrun: first word held, second dropped
      send(4'b1111, 0, 1'b0, "t3a");
      send(4'b0001, 0, 1'b0, "t3b");
      check("t3.ovr", int'(overrun), 1);
      check("t3.keep", int'(word_out), 1);
      idle(2, 1'b0, "t3.hold");
      idle(2, 1'b1, "t3.drain");

      // restart at bit2
      step(1'b1, 1'b1, 1'b1, 1'b1, "t4");
      step(1'b0, 1'b1, 1'b0, 1'b1, "t4");
      step(1'b0, 1'b1, 1'b1, 1'b1, "t4.abort");
      check("t4.ferr", int'(frame_err), 1);
      step(1'b1, 1'b1, 1'b0, 1'b1, "t4");
      step(1'b1, 1'b1, 1'b0, 1'b1, "t4");
      step(1'b0, 1'b1, 1'b0, 1'b1, "t4");
      check("t4.word", int'(word_out), 10);
      idle(1, 1'b1, "t4.drain");

      // gaps and back-to-back frames
      for (int f = 0; f < 40; f++)
         send($urandom_range(15, 0), (f < 20) ? 3 : 0, 1'b1, "t5");
      idle(2, 1'b1, "t5.drain");

      // async reset mid-frame
      step(1'b0, 1'b1, 1'b1, 1'b1, "t6");
      step(1'b1, 1'b1, 1'b0, 1'b1, "t6");
      #2 r = 1'b0;
      #1;
      m_reset();
      compare("t6.rst");
      #1 r = 1'b1;
      send(4'b1010, 0, 1'b1, "t6b");
      check("t6.word", int'(word_out), 6);
      idle(1, 1'b1, "t6.drain");

      // free-running random traffic
      for (int i = 0; i < 1500; i++)
         step(1'($urandom), ($urandom_range(3, 0) != 0),
              ($urandom_range(5, 0) == 0), ($urandom_range(2, 0) != 0),
              "rnd");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
